// File: rtl/xpt2046_touch_responder.sv
// rtl/xpt2046_touch_responder.sv - responder model of the XPT2046 touch ADC SPI far end.
// Optional build macro TOUCH_RESP_NOISE_EN adds LFSR jitter to X/Y/Z conversion results.
module xpt2046_touch_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] TEMP_VALUE  = 12'h3A0,
  parameter logic [11:0] IDLE_VALUE  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        t_sck,
  input  logic        t_cs,
  input  logic        t_sdi,
  output logic        t_sdo,
  output logic        t_irq,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [11:0] z1_val,
  input  logic [11:0] z2_val,
  input  logic        pressed,
  output logic [7:0]  last_cmd,
  output logic        frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_CMD, S_BUSY, S_DATA} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [6:0]             cmd_sh_q, cmd_sh_d;
  logic [11:0]            data_sh_q, data_sh_d;
  logic                   mode_q, mode_d;
  logic                   sdo_q, sdo_d;
  logic                   irq_q, irq_d;
  logic [7:0]             last_cmd_q, last_cmd_d;
  logic                   frame_done_q, frame_done_d;

  logic        sck_s, cs_s, sdi_s, sck_rise, sck_fall;
  logic        cmd_accept, final_rise;
  logic [7:0]  new_cmd;
  logic [11:0] chan_val, snap_val;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign new_cmd    = {cmd_sh_q, sdi_s};
  assign cmd_accept = ~cs_s & sck_rise & (state_q == S_CMD) & (cnt_q == 5'd7);
  assign final_rise = (cnt_q == (mode_q ? 5'd16 : 5'd20));

  assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], t_sck};
  assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], t_cs};
  assign sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], t_sdi};
  assign sck_prev_d = sck_s;

  always_comb begin
    chan_val = IDLE_VALUE;
    case (new_cmd[6:4])
      3'b001:         chan_val = y_pos;
      3'b101:         chan_val = x_pos;
      3'b011:         chan_val = z1_val;
      3'b100:         chan_val = z2_val;
      3'b000, 3'b111: chan_val = TEMP_VALUE;
      default:        chan_val = IDLE_VALUE;
    endcase
  end

`ifdef TOUCH_RESP_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        noisy;
  logic [13:0] noisy_sum;

  assign noisy     = new_cmd[6:4] inside {3'b001, 3'b101, 3'b011, 3'b100};
  // Low three LFSR bits taken as a two's-complement offset in -4..+3.
  assign noisy_sum = {2'b00, chan_val} + {{11{lfsr_q[2]}}, lfsr_q[2:0]};

  always_comb begin
    lfsr_d = lfsr_q;
    if (cmd_accept)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    snap_val = chan_val;
    if (noisy) begin
      if (noisy_sum[13])      snap_val = 12'h000;
      else if (noisy_sum[12]) snap_val = 12'hFFF;
      else                    snap_val = noisy_sum[11:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign snap_val = chan_val;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_sh_d     = cmd_sh_q;
    data_sh_d    = data_sh_q;
    mode_d       = mode_q;
    sdo_d        = sdo_q;
    last_cmd_d   = last_cmd_q;
    frame_done_d = 1'b0;
    if (cs_s) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      sdo_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HUNT: begin
          state_d = S_HUNT;
          if (sck_rise && sdi_s) begin
            state_d  = S_CMD;
            cnt_d    = 5'd1;
            cmd_sh_d = 7'd1;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            cnt_d    = cnt_q + 5'd1;
            cmd_sh_d = {cmd_sh_q[5:0], sdi_s};
            if (cmd_accept) begin
              last_cmd_d = new_cmd;
              mode_d     = new_cmd[3];
              data_sh_d  = snap_val;
              sdo_d      = 1'b0;
              state_d    = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // Rise 9 is the busy slot; D11 goes out on the fall after it so it is sampled on rise 10.
          sdo_d = 1'b0;
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
          end else if (sck_fall && cnt_q == 5'd9) begin
            sdo_d     = data_sh_q[11];
            data_sh_d = {data_sh_q[10:0], 1'b0};
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (sck_rise) begin
            if (final_rise) begin
              frame_done_d = 1'b1;
              sdo_d        = 1'b0;
              cnt_d        = 5'd0;
              state_d      = S_HUNT;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else if (sck_fall) begin
            sdo_d     = data_sh_q[11];
            data_sh_d = {data_sh_q[10:0], 1'b0};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    irq_d = ~(pressed & ~last_cmd_q[0] & ((state_q == S_IDLE) || (state_q == S_HUNT)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      sdi_sync_q   <= '0;
      sck_prev_q   <= 1'b0;
      cnt_q        <= 5'd0;
      cmd_sh_q     <= 7'd0;
      data_sh_q    <= 12'd0;
      mode_q       <= 1'b0;
      sdo_q        <= 1'b0;
      irq_q        <= 1'b1;
      last_cmd_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      sck_prev_q   <= sck_prev_d;
      cnt_q        <= cnt_d;
      cmd_sh_q     <= cmd_sh_d;
      data_sh_q    <= data_sh_d;
      mode_q       <= mode_d;
      sdo_q        <= sdo_d;
      irq_q        <= irq_d;
      last_cmd_q   <= last_cmd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign t_sdo      = sdo_q;
  assign t_irq      = irq_q;
  assign last_cmd   = last_cmd_q;
  assign frame_done = frame_done_q;

endmodule
